// File: rtl/fqueue_pkg.sv
// Fqueue shared definitions: entry field helpers
// and the wrap-safe deadline expiry test.
package fqueue_pkg;

  localparam int DL_WIDTH   = 8;
  localparam int DATA_WIDTH = 16;

  // Deadline field: top lw bits of a dw-bit entry.
  function automatic logic [63:0] entry_deadline(
    input logic [63:0] e,
    input int unsigned dw,
    input int unsigned lw
  );
    return (e >> (dw - lw)) & ((64'd1 << lw) - 64'd1);
  endfunction

  // Payload field: low dw-lw bits of the entry.
  function automatic logic [63:0] entry_payload(
    input logic [63:0] e,
    input int unsigned dw,
    input int unsigned lw
  );
    return e & ((64'd1 << (dw - lw)) - 64'd1);
  endfunction

  // Expired iff (dl - now) mod 2^lw is negative.
  function automatic logic is_expired(
    input logic [63:0] dl,
    input logic [63:0] now,
    input int unsigned lw
  );
    logic [63:0] d;
    d = dl - now;
    return d[lw-1];
  endfunction

endpackage

// File: rtl/fqueue_head_stage_if.sv
// Fqueue head output stream: valid/ready with
// payload and deadline of the head entry.
interface fqueue_head_stage_if #(
  parameter int P_W = 8,
  parameter int D_W = 8
);

  logic           valid;
  logic           ready;
  logic [P_W-1:0] data;
  logic [D_W-1:0] deadline;

  modport master (
    output valid, data, deadline,
    input  ready
  );

  modport slave (
    input  valid, data, deadline,
    output ready
  );

endinterface

// File: rtl/fqueue_skid_buf.sv
// Two-entry FIFO-ordered register buffer; the head
// entry is always held in r_e0.
module fqueue_skid_buf
  import fqueue_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_occ;

  // Push to tail, pop from head, shift on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_e0 <= i_data;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_e0;
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/fqueue_head_stage.sv
// Fqueue read-side head stage: pops sync_fifo,
// drops expired entries, streams the survivors.
module fqueue_head_stage
  import fqueue_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int DL_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic [DL_WIDTH-1:0]   now_time,
  input  logic                  drop_en,
  fqueue_head_stage_if.master   out_if,
  output logic                  drop_pulse,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int PW = DATA_WIDTH - DL_WIDTH;

  if (DL_WIDTH >= DATA_WIDTH || ADDR_WIDTH < 1) begin : g_param_chk
    $error("fqueue_head_stage: bad widths");
  end

  logic                  r_inflight;
  logic                  r_drop_pulse;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [1:0]            w_occ;
  logic [2:0]            w_level;
  logic [DL_WIDTH-1:0]   w_dl;
  logic                  w_exp;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_pop   = w_valid & out_if.ready;
  assign w_level = {1'b0, w_occ}
                 + {2'b00, r_inflight}
                 - {2'b00, w_pop};
  // Gate with rst_n so the pop request is 0 in reset.
  assign w_rd_en = rst_n & ~fifo_empty
                 & (w_level < 3'd2);
  assign fifo_rd_en = w_rd_en;

  assign w_dl = DL_WIDTH'(entry_deadline(
    64'(fifo_rd_data), DATA_WIDTH, DL_WIDTH));
  assign w_exp = is_expired(
    64'(w_dl), 64'(now_time), DL_WIDTH);
  assign w_drop = r_inflight & drop_en & w_exp;
  assign w_push = r_inflight & ~w_drop;

  // Track read latency and count discarded entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight   <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_inflight   <= w_rd_en;
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  fqueue_skid_buf #(
    .W (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (fifo_rd_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_valid),
    .o_occ   (w_occ)
  );

  assign out_if.valid    = w_valid;
  assign out_if.deadline = DL_WIDTH'(entry_deadline(
    64'(w_head), DATA_WIDTH, DL_WIDTH));
  assign out_if.data     = PW'(entry_payload(
    64'(w_head), DATA_WIDTH, DL_WIDTH));
  assign drop_pulse      = r_drop_pulse;
  assign drop_cnt        = r_drop_cnt;

endmodule

// File: doc/fqueue_head_stage.md
# fqueue_head_stage

Read-side head stage placed directly downstream of the Fqueue `sync_fifo`. It drives the FIFO read enable, absorbs the one-cycle RAM read latency, and discards entries whose EDF deadline has already passed. It presents the surviving entries to the EDF scheduler on a valid/ready stream with full one-per-cycle throughput.

## Interface
- `ADDR_WIDTH`, 9: address width of the upstream FIFO; kept only for parameter pass-through consistency.
- `DATA_WIDTH`, 16: FIFO entry width; `entry = {deadline[DL_WIDTH-1:0], payload[DATA_WIDTH-DL_WIDTH-1:0]}`.
- `DL_WIDTH`, 8: deadline/timestamp width; must satisfy `DL_WIDTH < DATA_WIDTH`.
- `CNT_WIDTH`, 16: width of the drop counter.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: upstream FIFO empty flag.
- `fifo_rd_en` out 1: pop request to the FIFO.
- `fifo_rd_data` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `now_time` in DL_WIDTH: free-running global time, in the same units as the deadline.
- `drop_en` in 1: when 1, expired entries are discarded; when 0, all entries pass through.
- `out_valid` out 1: the head entry is available.
- `out_ready` in 1: the consumer accepts the entry.
- `out_data` out DATA_WIDTH-DL_WIDTH: payload of the head entry.
- `out_deadline` out DL_WIDTH: deadline of the head entry.
- `drop_pulse` out 1: one-cycle pulse for each discarded entry.
- `drop_cnt` out CNT_WIDTH: saturating count of discarded entries.

## Operation
- **Reset values.** All outputs are 0 at reset: `fifo_rd_en`, `out_valid`, `out_data`, `out_deadline`, `drop_pulse`, `drop_cnt`. Internal state also resets: buffer occupancy `occ=0` and `inflight=0`.
- **Buffer state.** The 2-entry output buffer has occupancy states EMPTY(0), ONE(1), FULL(2). `inflight` is 1 in the cycle after `fifo_rd_en`.
- **Pop signal.** `pop = out_valid & out_ready`.
- **Read issue.** `fifo_rd_en = ~fifo_empty & (occ + inflight - pop < 2)`. This is combinational on registered state plus `out_ready`. It never asserts while `fifo_empty=1`.
- **Capture.** In a cycle with `inflight=1`, `fifo_rd_data` is evaluated:
  - `diff = deadline - now_time`, computed modulo 2^DL_WIDTH.
  - The entry is expired iff `diff[DL_WIDTH-1]==1`, i.e. a wrap-safe signed comparison. `deadline == now_time` is NOT expired.
  - If expired and `drop_en=1`: the entry is discarded, `drop_pulse=1` the next cycle, and `drop_cnt` increments, saturating at all-ones.
  - Otherwise the entry is written at the buffer tail.
- **Ordering.** The buffer is FIFO-ordered. `out_*` always shows `entry[0]`.
- **Simultaneous events.** Capture and pop in the same cycle leave occupancy unchanged. The buffer never overflows, because the issue rule guarantees it.
- **Stream stability.** `out_valid` and `out_data` stay stable while `out_valid & ~out_ready`.
- **Reset mid-operation.** Buffer contents and any in-flight read are lost. FIFO pointers are reset by the same `rst_n`, so no resynchronisation is needed.
- **`drop_en` timing.** `drop_en` and `now_time` are sampled at capture time only. Entries already buffered are never re-checked.

## Timing
- **Latency.** `fifo_rd_en` in cycle N → data on `fifo_rd_data` in N+1 → `out_valid` in N+2.
- **Earliest read.** With an empty stage, `fifo_rd_en` asserts in the same cycle `fifo_empty` falls.
- **Throughput.** One entry per cycle while `out_ready=1` and the FIFO is non-empty. In steady state `occ=1` and `inflight=1`.
- **Backpressure.** With `out_ready=0`, at most 2 entries are accepted, then `fifo_rd_en` deasserts. Reads resume in the same cycle `out_ready` returns.
- **Drop flags.** `drop_pulse` and the `drop_cnt` increment are visible 1 cycle after the capture cycle.

## Structure
- **Package `fqueue_pkg`.** Holds the `DL_WIDTH` default, the entry-field slice helpers (`entry_deadline`, `entry_payload`) and the `is_expired(deadline, now)` function. These are shared with the enqueue stage and the scheduler.
- **Sub-module `fqueue_skid_buf`.** A 2-entry register buffer with push, pop and `occ` outputs. It is instantiated once.
- **Top-level logic.** Read-issue logic, the `inflight` register, the expiry check and the drop counter sit in the top level.

## Test plan
- **Basic pass-through.** FIFO preloaded with 4 entries with deadlines 0x20..0x23, `now_time=0x10`, `out_ready=1`.
  - Expect `fifo_rd_en` high for 4 consecutive cycles.
  - Expect `out_valid` high for 4 consecutive cycles, starting 2 cycles after the first read.
  - Payloads arrive in order; `drop_cnt=0`.
- **Expiry drop.** Deadlines 0x05, 0x30, 0x04 with `now_time=0x10` and `drop_en=1`.
  - Only the 0x30 entry is output.
  - `drop_pulse` fires twice; `drop_cnt=2`.
  - Repeat with `drop_en=0`: all 3 entries are output and `drop_cnt` does not change.
- **Wrap-around.** `now_time=0xF8` with deadline 0x02: kept, since diff=0x0A. `now_time=0x02` with deadline 0xF8: dropped. `deadline==now_time`: kept.
- **Backpressure.** 6 entries queued, `out_ready=0`.
  - `fifo_rd_en` asserts exactly twice, then holds 0.
  - `out_data` is stable.
  - Raising `out_ready` drains all 6 entries back-to-back with no gap.
- **Empty and boundary.** `fifo_empty` toggles 1→0→1 with a single entry: exactly one read is issued and one `out_valid` cycle follows. `fifo_rd_en` is never asserted while `fifo_empty=1`.
- **Mid-stream reset, then saturation.**
  - Assert `rst_n=0` while `occ=2` and `inflight=1`: all outputs go to 0 immediately, and after release the stage is EMPTY.
  - With `CNT_WIDTH=4`, force 17 drops: `drop_cnt` holds at 0xF.
